ntsc_timing_gen: RTL
====================

// Module: ntsc_timing_gen
// PURPOSE
//  Composite NTSC 240p timing generator and 4-bit DAC level encoder. Runs on the
//  16 MHz PLL clock "clk". Counts pixels and lines, requests luma from the upstream
//  pixel source and drives the 4-bit vdac bus with sync, blank and video levels.
//  Sits directly downstream of the PLL/reset block; its reset is that block's reset.
// PARAMETERS
//  H_SYNC      75   hsync width, clocks (4.7 us @16 MHz)
//  H_BACK      75   back porch, clocks
//  H_ACTIVE    842  active video, clocks
//  H_FRONT     24   front porch, clocks (H_TOTAL = 1016 = 63.5 us)
//  V_ACTIVE    240  active lines
//  V_FRONT     3    front porch lines
//  V_SYNC      3    vsync (broad-pulse) lines
//  V_BACK      16   back porch lines (V_TOTAL = 262)
//  LVL_SYNC    0    DAC code for sync tip
//  LVL_BLANK   5    DAC code for blank/black
// PORTS
//  clk          in   1   16 MHz pixel clock
//  NRST         in   1   asynchronous active-low reset
//  px_req       out  1   pixel request; px_x/px_y valid this cycle
//  px_x         out  10  active pixel column, 0..H_ACTIVE-1
//  px_y         out  9   active line, 0..V_ACTIVE-1
//  px_luma      in   4   luma for the last request, valid 1 cycle after px_req
//  dac          out  4   DAC code to vdac pins
//  line_start   out  1   1-cycle pulse, aligned with first sync clock of each line on dac
//  frame_start  out  1   1-cycle pulse, aligned with line_start of line 0
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (NRST). On NRST=0: h_cnt=0,
//    v_cnt=0, px_req=0, px_x=0, px_y=0, dac=LVL_BLANK, line_start=0, frame_start=0.
//  - h_cnt 10b: 0..H_TOTAL-1, wraps to 0; v_cnt 9b increments on h wrap, 0..261, wraps.
//  - H states by h_cnt: SYNC [0,75), BACK [75,150), ACTIVE [150,992), FRONT [992,1016).
//  - V states by v_cnt: ACTIVE [0,240), FRONT [240,243), VSYNC [243,246), BACK [246,262).
//  - Pipeline: counters at cycle t -> px_req/px_x/px_y registered, visible t+1 ->
//    px_luma sampled t+2 -> dac registered, visible t+3. All dac/pulse outputs use the
//    same 3-cycle delay; the dac stream is exactly the counter sequence delayed.
//  - px_req=1 iff H=ACTIVE and V=ACTIVE; px_x=h_cnt-150, px_y=v_cnt; x/y hold last
//    value when px_req=0. Upstream must return luma with fixed 1-cycle latency.
//  - dac encoding for a non-VSYNC line: SYNC -> LVL_SYNC; BACK/FRONT -> LVL_BLANK;
//    ACTIVE on V ACTIVE lines -> max(px_luma, LVL_BLANK) (luma below blank clamps);
//    ACTIVE on FRONT/BACK lines -> LVL_BLANK.
//  - VSYNC lines (inverted/broad sync): h_cnt < H_TOTAL-H_SYNC -> LVL_SYNC,
//    else LVL_BLANK. No px_req on VSYNC lines.
//  - line_start at dac cycle of h_cnt=0; frame_start only when also v_cnt=0.
//  - Wrap: h_cnt=1015 -> 0 and v_cnt=261 -> 0 in the same cycle; no skipped/extra line.
//  - Reset mid-line/mid-frame: immediate asynchronous clear of all counters and
//    pipeline; after NRST rises, first dac sync tip appears 3 cycles later with
//    line_start/frame_start both 1. No partial request is completed.
//  - Frame = 1016*262 = 266192 clocks exactly, every frame.
// TESTING
//  1 Release NRST, run 2 frames -> frame_start period 266192 clks, line_start 1016.
//  2 Active line, px_luma=15 -> dac 0 x75, 5 x75, 15 x842, 5 x24; 842 px_req with
//    px_x 0..841 consecutive.
//  3 px_luma=2 on line 10 -> active dac held at 5 (clamp); px_luma=9 -> dac=9.
//  4 Line 244 -> dac 0 for 941 clks then 5 for 75; px_req=0 for all of lines 240..261.
//  5 Assert NRST at v_cnt=100,h_cnt=500 -> dac=5, px_req=0 immediately; release ->
//    line_start+frame_start together 3 clks later, next px_y=0.
//  6 Ramp luma=px_x[3:0] -> dac sample n equals clamp(luma of request n), 2-cycle skew.

Source files
------------

// File: rtl/ntsc_timing_gen_if.sv
// Pixel-request and DAC output bundle of the NTSC timing generator.
`timescale 1ns/1ps
interface ntsc_timing_gen_if;
  logic       px_req;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic [3:0] px_luma;
  logic [3:0] dac;
  logic       line_start;
  logic       frame_start;

  modport master (
    output px_req, px_x, px_y, dac, line_start, frame_start,
    input  px_luma
  );

  modport slave (
    input  px_req, px_x, px_y, dac, line_start, frame_start,
    output px_luma
  );
endinterface

// File: rtl/ntsc_timing_gen.sv
// Composite NTSC 240p timing generator: pixel/line counters, upstream luma
// request and 4-bit DAC level encoding with a fixed 3-cycle output pipeline.
//
// h_state | meaning
// SYNC    | horizontal sync tip
// BACK    | back porch (blank)
// ACTIVE  | active video columns
// FRONT   | front porch (blank)
//
// v_state | meaning
// ACTIVE  | visible lines, pixels requested
// FRONT   | blank lines before vsync
// VSYNC   | broad-pulse (inverted) sync lines
// BACK    | blank lines after vsync
`timescale 1ns/1ps
module ntsc_timing_gen #(
  parameter int         H_SYNC    = 75,
  parameter int         H_BACK    = 75,
  parameter int         H_ACTIVE  = 842,
  parameter int         H_FRONT   = 24,
  parameter int         V_ACTIVE  = 240,
  parameter int         V_FRONT   = 3,
  parameter int         V_SYNC    = 3,
  parameter int         V_BACK    = 16,
  parameter logic [3:0] LVL_SYNC  = 4'd0,
  parameter logic [3:0] LVL_BLANK = 4'd5
) (
  input  logic clk,
  input  logic NRST,
  ntsc_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_SYNC_LAST  = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BACK_LAST  = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_ACT_START  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_LAST   = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_BROAD_END  = 10'(H_TOTAL - H_SYNC);

  localparam logic [8:0] V_ACT_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [8:0] V_FRONT_LAST = 9'(V_ACTIVE + V_FRONT - 1);
  localparam logic [8:0] V_SYNC_LAST  = 9'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);

  typedef enum logic [1:0] {HS_SYNC, HS_BACK, HS_ACTIVE, HS_FRONT} h_state_t;
  typedef enum logic [1:0] {VS_ACTIVE, VS_FRONT, VS_SYNC, VS_BACK} v_state_t;

  h_state_t   h_state, h_state_nxt;
  v_state_t   v_state, v_state_nxt;
  logic [9:0] h_cnt, h_cnt_nxt;
  logic [8:0] v_cnt, v_cnt_nxt;
  logic       h_last, v_last;
  logic       req, lvl_sync;

  logic       s1_sync, s1_video, s1_line, s1_frame;
  logic       s2_sync, s2_video, s2_line, s2_frame;
  logic [3:0] luma_clamped;

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_state <= HS_SYNC;
      v_state <= VS_ACTIVE;
    end else begin
      h_cnt   <= h_cnt_nxt;
      v_cnt   <= v_cnt_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  always_comb begin
    h_last      = (h_cnt == H_LAST);
    v_last      = (v_cnt == V_LAST);
    h_cnt_nxt   = h_last ? '0 : h_cnt + 10'd1;
    v_cnt_nxt   = v_cnt;
    h_state_nxt = h_state;
    v_state_nxt = v_state;

    if (h_last)
      v_cnt_nxt = v_last ? '0 : v_cnt + 9'd1;

    case (h_state)
      HS_SYNC:   if (h_cnt == H_SYNC_LAST) h_state_nxt = HS_BACK;
      HS_BACK:   if (h_cnt == H_BACK_LAST) h_state_nxt = HS_ACTIVE;
      HS_ACTIVE: if (h_cnt == H_ACT_LAST)  h_state_nxt = HS_FRONT;
      HS_FRONT:  if (h_last)               h_state_nxt = HS_SYNC;
      default:                             h_state_nxt = HS_SYNC;
    endcase

    if (h_last) begin
      case (v_state)
        VS_ACTIVE: if (v_cnt == V_ACT_LAST)   v_state_nxt = VS_FRONT;
        VS_FRONT:  if (v_cnt == V_FRONT_LAST) v_state_nxt = VS_SYNC;
        VS_SYNC:   if (v_cnt == V_SYNC_LAST)  v_state_nxt = VS_BACK;
        VS_BACK:   if (v_last)                v_state_nxt = VS_ACTIVE;
        default:                              v_state_nxt = VS_ACTIVE;
      endcase
    end

    req = (h_state == HS_ACTIVE) && (v_state == VS_ACTIVE);
    // Broad pulses: sync level for all but the last H_SYNC clocks of the line.
    if (v_state == VS_SYNC)
      lvl_sync = (h_cnt < H_BROAD_END);
    else
      lvl_sync = (h_state == HS_SYNC);
  end

  always_comb begin
    luma_clamped = (vid.px_luma < LVL_BLANK) ? LVL_BLANK : vid.px_luma;
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      vid.px_req      <= 1'b0;
      vid.px_x        <= '0;
      vid.px_y        <= '0;
      s1_sync         <= 1'b0;
      s1_video        <= 1'b0;
      s1_line         <= 1'b0;
      s1_frame        <= 1'b0;
      s2_sync         <= 1'b0;
      s2_video        <= 1'b0;
      s2_line         <= 1'b0;
      s2_frame        <= 1'b0;
      vid.dac         <= LVL_BLANK;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else begin
      vid.px_req <= req;
      if (req) begin
        vid.px_x <= h_cnt - H_ACT_START;
        vid.px_y <= v_cnt;
      end
      s1_sync  <= lvl_sync;
      s1_video <= req;
      s1_line  <= (h_cnt == '0);
      s1_frame <= (h_cnt == '0) && (v_cnt == '0);

      s2_sync  <= s1_sync;
      s2_video <= s1_video;
      s2_line  <= s1_line;
      s2_frame <= s1_frame;

      // Luma for the stage-2 request is on the bus this cycle.
      if (s2_video)
        vid.dac <= luma_clamped;
      else if (s2_sync)
        vid.dac <= LVL_SYNC;
      else
        vid.dac <= LVL_BLANK;
      vid.line_start  <= s2_line;
      vid.frame_start <= s2_frame;
    end
  end

endmodule
